tx_arbiter: RTL
===============

# tx_arbiter

Registered, starvation-safe transmit arbiter between the three TX flit sources of a node: the ack queue, the waiting-ack (retransmit) buffer and the forwarding buffer. Fixed priority ack > retransmit > forward is the default policy. Per-source aging counters force a grant to a lower-priority source that has been bypassed too often. The winning flit is captured in a one-entry output register that drives the physical-layer transmitter.

## Interface
- STARVE_LIMIT, default 4: number of consecutive bypassed grants after which a valid retransmit or forward source is forced; legal range 1..15.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- ack_flit  in  types::flit_t  ack source flit
- ack_flit_valid  in  1  ack source valid
- ack_flit_ready  out  1  ack flit accepted this cycle
- waiting_ack_buffer_flit  in  types::flit_t  retransmit source flit
- waiting_ack_buffer_valid  in  1  retransmit source valid
- waiting_ack_buffer_ready  out  1  retransmit flit accepted this cycle
- forwarded_flit  in  types::flit_t  forward source flit
- forwarded_flit_valid  in  1  forward source valid
- forwarded_flit_ready  out  1  forward flit accepted this cycle
- flit_out  out  types::flit_t  registered output flit
- flit_out_valid  out  1  output register full
- flit_out_ready  in  1  downstream accepts flit_out
- grant_src  out  types::tx_src_t  source of the flit held in the output register
- starve_override  out  1  held flit was granted by aging override, not by priority

## Operation
- Output register has two states: EMPTY (flit_out_valid=0) and FULL (flit_out_valid=1).
- accept_en = !flit_out_valid || flit_out_ready.
- Pick, evaluated combinationally every cycle:
  - If waiting_ack_buffer_valid and cnt_retx==STARVE_LIMIT, pick retransmit.
  - Else if forwarded_flit_valid and cnt_fwd==STARVE_LIMIT, pick forward.
  - Else pick the highest-priority valid source: ack, then retransmit, then forward.
- Exactly one *_ready is high, for the picked source, and only when accept_en=1. All *_ready are 0 otherwise.
- On accept: the output register loads the picked flit, sets grant_src and starve_override, and goes FULL.
- When downstream takes the flit (flit_out_ready=1) and no source is valid, the register goes EMPTY.
- Aging counters cnt_retx and cnt_fwd:
  - Width is $clog2(STARVE_LIMIT+1).
  - Updated only on a cycle where an accept occurs:
    - owner granted: counter to 0
    - owner valid but not granted: counter to min(cnt+1, STARVE_LIMIT)
  - A counter clears to 0 on any cycle its owner's valid is low, whether or not an accept occurs.
  - Counters hold when no accept occurs and the owner is valid.
- Both counters at the limit: retransmit wins. Forward stays saturated and wins the next grant.
- The ack source has no counter and is never forced.

## Timing
- Reset values: flit_out=0, flit_out_valid=0, grant_src=TX_SRC_NONE, starve_override=0, all *_ready=0, both counters 0.
- rst has priority over every other event. Reset during FULL drops the held flit; it is not retransmitted.
- Latency is 1 cycle: a flit accepted at edge N appears on flit_out after edge N.
- Throughput is 1 flit/cycle while flit_out_ready=1.
- No combinational path from any *_flit to flit_out. *_ready depends combinationally on flit_out_ready and the source valids.
- FULL with flit_out_ready=0:
  - flit_out, grant_src and starve_override hold stable.
  - All *_ready=0.
  - Counters hold, except that a counter clears when its owner's valid drops.
- Drain and refill happen in the same cycle when FULL, flit_out_ready=1 and a source is valid.

## Structure
- Package types gains typedef enum logic [1:0] tx_src_t: TX_SRC_NONE=0, TX_SRC_ACK=1, TX_SRC_RETX=2, TX_SRC_FWD=3.
- Sub-module tx_arbiter_pick_comb takes the valids and both at-limit flags and returns a one-hot grant plus an override flag.
- The parent module holds the output register, the counters and the ready generation.

## Test plan
- Reset with all valids high and flit_out_ready=1 -> all *_ready=0 while rst=1; every output at its reset value one cycle after rst falls, before any accept.
- Single forward flit 0xA5, register EMPTY -> forwarded_flit_ready=1 in the same cycle; next cycle flit_out=0xA5, flit_out_valid=1, grant_src=TX_SRC_FWD, starve_override=0.
- STARVE_LIMIT=4, all three sources valid continuously, flit_out_ready=1 -> grant sequence A,A,A,A,R,F,A,A,A,R,F,A,A,A,R,F; starve_override=1 exactly on the R and F grants.
- Register FULL, flit_out_ready=0 for 5 cycles with all sources valid -> flit_out stable, all *_ready=0, counters unchanged. flit_out_ready=1 -> new flit loaded the same cycle, 1 flit/cycle afterwards.
- Retransmit bypassed 3 times (cnt_retx=3), then waiting_ack_buffer_valid low for 1 cycle, then high again -> counter restarts at 0; override only after 4 further bypassed grants.
- rst asserted while FULL with counters at 2 -> next cycle flit_out_valid=0, both counters 0, grant_src=TX_SRC_NONE.

Source files
------------

// File: rtl/tx_arbiter_pkg.sv
// tx_arbiter_pkg: flit and transmit-source types shared by the TX arbiter
package types;
   localparam int FLIT_W = 16;
   typedef logic [FLIT_W-1:0] flit_t;
   typedef enum logic [1:0] {
      TX_SRC_NONE = 2'd0,
      TX_SRC_ACK  = 2'd1,
      TX_SRC_RETX = 2'd2,
      TX_SRC_FWD  = 2'd3
   } tx_src_t;
   function automatic tx_src_t grant_to_src(input logic [2:0] g);
      return g[0] ? TX_SRC_ACK : g[1] ? TX_SRC_RETX : g[2] ? TX_SRC_FWD : TX_SRC_NONE;
   endfunction
endpackage

// File: rtl/tx_arbiter_pick_comb.sv
// tx_arbiter_pick_comb: aging-aware fixed-priority pick, one-hot {fwd, retx, ack}
module tx_arbiter_pick_comb (
   input  logic       ack_valid,
   input  logic       retx_valid,
   input  logic       fwd_valid,
   input  logic       retx_at_limit,
   input  logic       fwd_at_limit,
   output logic [2:0] grant,
   output logic       override
);
   logic force_retx, force_fwd;
   always_comb begin
      force_retx = retx_valid && retx_at_limit;
      force_fwd  = fwd_valid && fwd_at_limit;
      override   = force_retx || force_fwd;
      grant      = force_retx ? 3'b010 : force_fwd ? 3'b100 : ack_valid ? 3'b001 :
                   retx_valid ? 3'b010 : fwd_valid ? 3'b100 : 3'b000;
   end
endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: starvation-safe TX arbiter with a one-entry registered output
module tx_arbiter
   import types::*;
#(
   parameter int STARVE_LIMIT = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  flit_t   ack_flit,
   input  logic    ack_flit_valid,
   output logic    ack_flit_ready,
   input  flit_t   waiting_ack_buffer_flit,
   input  logic    waiting_ack_buffer_valid,
   output logic    waiting_ack_buffer_ready,
   input  flit_t   forwarded_flit,
   input  logic    forwarded_flit_valid,
   output logic    forwarded_flit_ready,
   output flit_t   flit_out,
   output logic    flit_out_valid,
   input  logic    flit_out_ready,
   output tx_src_t grant_src,
   output logic    starve_override
);
   localparam int CW = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);
   logic [CW-1:0] cnt_retx, cnt_fwd;
   logic [2:0] grant;
   logic override, accept_en, accept;
   tx_arbiter_pick_comb u_pick (
      .ack_valid     (ack_flit_valid),
      .retx_valid    (waiting_ack_buffer_valid),
      .fwd_valid     (forwarded_flit_valid),
      .retx_at_limit (cnt_retx == LIM),
      .fwd_at_limit  (cnt_fwd == LIM),
      .grant         (grant),
      .override      (override)
   );
   always_comb begin
      accept_en                = !rst && (!flit_out_valid || flit_out_ready);
      accept                   = accept_en && |grant;
      ack_flit_ready           = accept_en && grant[0];
      waiting_ack_buffer_ready = accept_en && grant[1];
      forwarded_flit_ready     = accept_en && grant[2];
   end
   // a counter tracks consecutive bypasses only while its owner stays valid
   always_ff @(posedge clk) begin
      if (rst) begin
         flit_out        <= '0;
         flit_out_valid  <= 1'b0;
         grant_src       <= TX_SRC_NONE;
         starve_override <= 1'b0;
         cnt_retx        <= '0;
         cnt_fwd         <= '0;
      end else begin
         if (accept) begin
            flit_out        <= grant[0] ? ack_flit : grant[1] ? waiting_ack_buffer_flit : forwarded_flit;
            grant_src       <= grant_to_src(grant);
            starve_override <= override;
            flit_out_valid  <= 1'b1;
         end else if (flit_out_ready) begin
            flit_out_valid  <= 1'b0;
         end
         cnt_retx <= !waiting_ack_buffer_valid ? '0 : !accept ? cnt_retx : grant[1] ? '0 :
                     (cnt_retx == LIM) ? LIM : cnt_retx + 1'b1;
         cnt_fwd  <= !forwarded_flit_valid ? '0 : !accept ? cnt_fwd : grant[2] ? '0 :
                     (cnt_fwd == LIM) ? LIM : cnt_fwd + 1'b1;
      end
   end
endmodule
